// File: rtl/uart_echo_if.sv
// uart_echo_if: UART-side handshake, transform control and status bundle for uart_echo_engine.
interface uart_echo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [1:0]        mode;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              tx_busy;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              clr;
  logic [LW-1:0]     rx_level;
  logic [LW-1:0]     tx_level;
  logic              overflow;
  logic [15:0]       drop_count;
  logic [15:0]       tx_count;

  // Board/UART side: drives receive strobes, busy and control.
  modport master (
    output mode, rx_valid, rx_data, tx_busy, clr,
    input  tx_start, tx_data, rx_level, tx_level, overflow, drop_count, tx_count
  );

  // Engine side.
  modport slave (
    input  mode, rx_valid, rx_data, tx_busy, clr,
    output tx_start, tx_data, rx_level, tx_level, overflow, drop_count, tx_count
  );
endinterface

// File: rtl/uart_echo_engine.sv
// uart_echo_engine: RX FIFO -> transform -> TX FIFO -> UART start/busy handshake.
// Optional statistics counters enabled by defining UART_ECHO_STATS_EN.
module uart_echo_engine #(
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       DEPTH        = 16,
  parameter logic [DATA_W-1:0] OFFSET       = DATA_W'(1),
  parameter logic [DATA_W-1:0] XOR_KEY      = DATA_W'(8'h20),
  parameter int unsigned       BUSY_TIMEOUT = 4
) (
  input logic             clk,
  input logic             rst,
  uart_echo_if.slave      bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [DATA_W-1:0] UP_LO   = DATA_W'(8'h41);
  localparam logic [DATA_W-1:0] UP_HI   = DATA_W'(8'h5A);
  localparam logic [DATA_W-1:0] LO_LO   = DATA_W'(8'h61);
  localparam logic [DATA_W-1:0] LO_HI   = DATA_W'(8'h7A);
  localparam logic [DATA_W-1:0] CASE_BIT = DATA_W'(8'h20);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_e;

  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [DATA_W-1:0] tx_mem [DEPTH];

  logic [AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [LW-1:0] rx_level_q, tx_level_q;
  logic        overflow_q;
  logic        tx_start_q;
  logic [DATA_W-1:0] tx_data_q;

  state_e      state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic        issue;

  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rx_push, drop, xfer;
  logic [DATA_W-1:0] rx_head, xf_data;

  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign tx_empty = (tx_wr_q == tx_rd_q);

  assign rx_push = bus.rx_valid && !rx_full;
  assign drop    = bus.rx_valid && rx_full;
  assign xfer    = !rx_empty && !tx_full;
  assign rx_head = rx_mem[rx_rd_q[AW-1:0]];

  // Transform stage applied to the RX head in the transfer cycle.
  always_comb begin
    xf_data = rx_head;
    case (bus.mode)
      2'd0: xf_data = rx_head;
      2'd1: xf_data = rx_head + OFFSET;
      2'd2: xf_data = rx_head ^ XOR_KEY;
      default: begin
        if ((DATA_W == 8) &&
            (((rx_head >= UP_LO) && (rx_head <= UP_HI)) ||
             ((rx_head >= LO_LO) && (rx_head <= LO_HI)))) begin
          xf_data = rx_head ^ CASE_BIT;
        end
      end
    endcase
  end

  // Next pointer values for both FIFOs.
  always_comb begin
    rx_wr_d = rx_wr_q + LW'(rx_push);
    rx_rd_d = rx_rd_q + LW'(xfer);
    tx_wr_d = tx_wr_q + LW'(xfer);
    tx_rd_d = tx_rd_q + LW'(issue);
  end

  // FIFO storage; only pointers are reset.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= bus.rx_data;
    if (xfer)    tx_mem[tx_wr_q[AW-1:0]] <= xf_data;
  end

  // Pointers, levels and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_level_q <= '0;
      tx_level_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      rx_level_q <= rx_wr_d - rx_rd_d;
      tx_level_q <= tx_wr_d - tx_rd_d;
      if (drop)         overflow_q <= 1'b1;
      else if (bus.clr) overflow_q <= 1'b0;
    end
  end

  // TX FSM state register and registered start/data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_start_q <= issue;
      if (issue) tx_data_q <= tx_mem[tx_rd_q[AW-1:0]];
    end
  end

  // TX FSM next state: issue a word, wait for busy to rise (with timeout), wait for it to fall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_empty && !bus.tx_busy) begin
          issue   = 1'b1;
          state_d = WAIT_BUSY;
          cnt_d   = '0;
        end
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_ECHO_STATS_EN
  logic [15:0] drop_cnt_q, tx_cnt_q;

  // Statistics: saturating drop count, wrapping start count; an event in a clr cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
      tx_cnt_q   <= '0;
    end else begin
      if (drop) begin
        if (bus.clr)                    drop_cnt_q <= 16'd1;
        else if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end else if (bus.clr) begin
        drop_cnt_q <= '0;
      end
      if (issue) begin
        tx_cnt_q <= bus.clr ? 16'd1 : tx_cnt_q + 16'd1;
      end else if (bus.clr) begin
        tx_cnt_q <= '0;
      end
    end
  end

  assign bus.drop_count = drop_cnt_q;
  assign bus.tx_count   = tx_cnt_q;
`else
  assign bus.drop_count = 16'h0000;
  assign bus.tx_count   = 16'h0000;
`endif

  assign bus.rx_level = rx_level_q;
  assign bus.tx_level = tx_level_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_echo_engine.sv
// tb_uart_echo_engine: scoreboard bench with a behavioural transform model and a simple UART busy model.
module tb_uart_echo_engine;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO   = 4;
`ifdef UART_ECHO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_echo_if #(.DATA_W(8), .DEPTH(DEPTH)) bus ();

  uart_echo_engine #(
    .DATA_W(8), .DEPTH(DEPTH), .OFFSET(8'd1), .XOR_KEY(8'h20), .BUSY_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int sent = 0;
  int started = 0;
  int exp_tx_count = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int start_times[$];

  bit busy_force = 1'b0;
  bit busy_never = 1'b0;
  int busy_len_fixed = 0;
  int busy_cnt = 0;
  bit prev_start = 1'b0;
  logic [7:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference transform, from the mode rules.
  function automatic logic [7:0] ref_xf(input int m, input logic [7:0] b);
    case (m)
      1: return 8'(b + 8'd1);
      2: return b ^ 8'h20;
      3: begin
        if (b >= "A" && b <= "Z") return 8'(b + 8'd32);
        if (b >= "a" && b <= "z") return 8'(b - 8'd32);
        return b;
      end
      default: return b;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy rises in the start cycle and stays up for a few cycles.
  always @(negedge clk) begin
    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    if (bus.tx_start && !busy_never)
      busy_cnt = (busy_len_fixed != 0) ? busy_len_fixed : int'($urandom_range(1, 4));
    bus.tx_busy = busy_force || (busy_cnt > 0);
  end

  // Monitor: every start pops the scoreboard and compares tx_data.
  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
    end else begin
      if (bus.tx_start) begin
        chk("start_not_back_to_back", 32'(prev_start), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got tx_data %0h, required no start (t=%0t)", bus.tx_data, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("tx_data", 32'(bus.tx_data), 32'(mon_exp));
        end
        started++;
        exp_tx_count++;
        start_times.push_back(cyc);
      end
      prev_start = bus.tx_start;
    end
  end

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    sent++;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_complete", 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int base;
    int n;
    int m;
    logic [7:0] b;

    bus.mode = 2'd1; bus.rx_valid = 1'b0; bus.rx_data = '0; bus.clr = 1'b0; bus.tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_rx_level", 32'(bus.rx_level), 32'd0);
    chk("rst_tx_level", 32'(bus.tx_level), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_drop_count", 32'(bus.drop_count), 32'd0);
    chk("rst_tx_count", 32'(bus.tx_count), 32'd0);

    // Mode 1 latency: 0x41 -> 0x42 three cycles after rx_valid.
    exp_q.push_back(8'h42);
    send(8'h41);
    chk("lat_rx_level_n1", 32'(bus.rx_level), 32'd1);
    @(negedge clk);
    chk("lat_tx_level_n2", 32'(bus.tx_level), 32'd1);
    @(negedge clk);
    chk("lat_tx_start_n3", 32'(bus.tx_start), 32'd1);
    chk("lat_tx_data_n3", 32'(bus.tx_data), 32'h42);
    exp_q.push_back(8'h00);
    send(8'hFF);
    wait_drain();

    // Mode 3 case swap, then mode 2 XOR.
    bus.mode = 2'd3;
    exp_q.push_back(8'h41); exp_q.push_back(8'h7A); exp_q.push_back(8'h31);
    send("a"); send("Z"); send("1");
    wait_drain();
    bus.mode = 2'd2;
    exp_q.push_back(8'h41);
    send(8'h61);
    wait_drain();

    // Randomised traffic per mode, never exceeding total FIFO capacity.
    for (int blk = 0; blk < 8; blk++) begin
      m = int'($urandom_range(0, 3));
      bus.mode = 2'(m);
      @(negedge clk);
      n = int'($urandom_range(8, 40));
      for (int i = 0; i < n; i++) begin
        int w = 0;
        while ((sent - started) >= 28 && w < 500) begin
          @(negedge clk);
          w++;
        end
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(ref_xf(m, b));
        send(b);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      wait_drain();
    end
    chk("tx_count_after_random", 32'(bus.tx_count), STATS ? 32'(exp_tx_count) : 32'd0);

    // Busy held: 2*DEPTH+3 words, 3 dropped, then release and drain in order.
    bus.mode = 2'd0;
    busy_force = 1'b1;
    repeat (2) @(negedge clk);
    base = started;
    for (int i = 0; i < 2 * DEPTH + 3; i++) begin
      b = 8'(i + 8'h10);
      if (i < 2 * DEPTH) exp_q.push_back(b);
      send(b);
    end
    repeat (3) @(negedge clk);
    chk("hold_rx_level", 32'(bus.rx_level), 32'(DEPTH));
    chk("hold_tx_level", 32'(bus.tx_level), 32'(DEPTH));
    chk("hold_overflow", 32'(bus.overflow), 32'd1);
    chk("hold_drop_count", 32'(bus.drop_count), STATS ? 32'd3 : 32'd0);
    chk("hold_no_start", 32'(started - base), 32'd0);
    busy_force = 1'b0;
    wait_drain();
    chk("hold_words_out", 32'(started - base), 32'(2 * DEPTH));

    // Drop coincident with clr, then clr alone.
    busy_force = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send(b);
    end
    repeat (2) @(negedge clk);
    bus.rx_valid = 1'b1; bus.rx_data = 8'hEE; bus.clr = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0; bus.clr = 1'b0;
    exp_tx_count = 0;
    chk("clrdrop_overflow", 32'(bus.overflow), 32'd1);
    chk("clrdrop_drop_count", 32'(bus.drop_count), STATS ? 32'd1 : 32'd0);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    chk("clr_overflow", 32'(bus.overflow), 32'd0);
    chk("clr_drop_count", 32'(bus.drop_count), 32'd0);
    chk("clr_tx_count", 32'(bus.tx_count), 32'd0);
    busy_force = 1'b0;
    wait_drain();
    chk("tx_count_after_clr", 32'(bus.tx_count), STATS ? 32'(2 * DEPTH) : 32'd0);

    // Busy never rises: timeout returns to IDLE and the next word starts.
    busy_never = 1'b1;
    bus.mode = 2'd1;
    repeat (6) @(negedge clk);
    start_times.delete();
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    send(8'h00); send(8'h01);
    wait_drain();
    chk("timeout_starts", 32'(start_times.size()), 32'd2);
    if (start_times.size() == 2)
      chk("timeout_spacing", 32'(start_times[1] - start_times[0]), 32'(TMO + 1));
    chk("timeout_tx_count", 32'(bus.tx_count), STATS ? 32'(exp_tx_count) : 32'd0);
    busy_never = 1'b0;

    // Reset with words queued behind a long transmission.
    bus.mode = 2'd0;
    busy_len_fixed = 30;
    base = started;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(8'(8'hA0 + i));
      send(8'(8'hA0 + i));
    end
    n = 0;
    while (started == base && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("pre_rst_queued", 32'(bus.rx_level) + 32'(bus.tx_level), 32'd5);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    exp_tx_count = 0;
    chk("mid_rst_rx_level", 32'(bus.rx_level), 32'd0);
    chk("mid_rst_tx_level", 32'(bus.tx_level), 32'd0);
    chk("mid_rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("mid_rst_tx_count", 32'(bus.tx_count), 32'd0);
    repeat (50) @(negedge clk);
    chk("mid_rst_no_more_starts", 32'(started - base), 32'd1);
    busy_len_fixed = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
